// File: rtl/div_scheduler.sv
// Two-requester front end for an external pipelined divider: round-robin issue,
// sign/zero handling around the unsigned divider, and an in-order response FIFO.
module div_scheduler #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CYCLE = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_dividend,
  input  logic [2*WIDTH-1:0] req_divisor,
  input  logic [1:0]         req_signed,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  input  logic [WIDTH-1:0]   div_quotient,
  input  logic [WIDTH-1:0]   div_remainder,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [WIDTH-1:0]   resp_quotient,
  output logic [WIDTH-1:0]   resp_remainder,
  output logic               resp_dbz
);

  localparam int unsigned LAT = CYCLE - 1;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             vld;
    logic             id;
    logic             sgn;
    logic             a_msb;
    logic             b_msb;
    logic             dbz;
    logic [WIDTH-1:0] dividend;
  } sb_t;

  typedef struct packed {
    logic             id;
    logic             dbz;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
  } resp_t;

  logic          last_q;
  logic [CW-1:0] credits_q, credits_d;
  sb_t           sb_q [LAT];
  sb_t           sb_in;
  sb_t           tail;
  resp_t         mem_q [DEPTH];
  resp_t         resp_in;
  resp_t         head;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]       grant;
  logic             issue, issue_id, push, pop, sgn_sel;
  logic [WIDTH-1:0] a_sel, b_sel;

  // Tie goes to the requester that did not issue last.
  always_comb begin
    grant = '0;
    if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
    else                    grant = req_valid;
  end

  assign req_ready = (reset && credits_q != '0) ? grant : '0;
  assign issue     = |(req_valid & req_ready);
  assign issue_id  = req_ready[1];
  assign a_sel     = issue_id ? req_dividend[WIDTH +: WIDTH] : req_dividend[0 +: WIDTH];
  assign b_sel     = issue_id ? req_divisor[WIDTH +: WIDTH]  : req_divisor[0 +: WIDTH];
  assign sgn_sel   = req_signed[issue_id];

  always_comb begin
    div_dividend = '0;
    div_divisor  = '0;
    if (issue) begin
      div_dividend = (sgn_sel && a_sel[WIDTH-1]) ? -a_sel : a_sel;
      div_divisor  = (sgn_sel && b_sel[WIDTH-1]) ? -b_sel : b_sel;
    end
  end

  always_comb begin
    sb_in          = '0;
    sb_in.vld      = issue;
    sb_in.id       = issue_id;
    sb_in.sgn      = sgn_sel;
    sb_in.a_msb    = a_sel[WIDTH-1];
    sb_in.b_msb    = b_sel[WIDTH-1];
    sb_in.dbz      = (b_sel == '0);
    sb_in.dividend = a_sel;
  end

  assign tail = sb_q[LAT-1];
  assign push = tail.vld;
  assign pop  = resp_valid && resp_ready;

  always_comb begin
    resp_in     = '0;
    resp_in.id  = tail.id;
    resp_in.dbz = tail.dbz;
    if (tail.dbz) begin
      resp_in.q = '1;
      resp_in.r = tail.dividend;
    end else begin
      resp_in.q = (tail.sgn && (tail.a_msb ^ tail.b_msb)) ? -div_quotient : div_quotient;
      resp_in.r = (tail.sgn && tail.a_msb) ? -div_remainder : div_remainder;
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (issue && !pop)      credits_d = credits_q - CW'(1);
    else if (pop && !issue) credits_d = credits_q + CW'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q    <= 1'b1;
      credits_q <= CW'(DEPTH);
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < LAT; i++) sb_q[i] <= '0;
    end else begin
      if (issue) last_q <= issue_id;
      credits_q <= credits_d;
      cnt_q     <= cnt_d;
      if (push) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (pop)  rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      sb_q[0] <= sb_in;
      for (int unsigned i = 1; i < LAT; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= resp_in;
  end

  assign head           = mem_q[rd_q];
  assign resp_valid     = (cnt_q != '0);
  assign resp_id        = resp_valid ? head.id  : 1'b0;
  assign resp_dbz       = resp_valid ? head.dbz : 1'b0;
  assign resp_quotient  = resp_valid ? head.q   : '0;
  assign resp_remainder = resp_valid ? head.r   : '0;

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a behavioural 7-stage unsigned divider.
module tb_div_scheduler;

  localparam int L = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_dividend, req_divisor;
  logic [1:0]  req_signed;
  logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic        resp_valid, resp_ready, resp_id, resp_dbz;
  logic [31:0] resp_quotient, resp_remainder;

  int n_checks = 0;
  int n_fail   = 0;

  div_scheduler #(.WIDTH(32), .CYCLE(8), .DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .req_signed(req_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder), .resp_dbz(resp_dbz)
  );

  always #5 clk = ~clk;

  // External divider: unsigned, L cycles from operands to results, never reset.
  logic [31:0] pq [L];
  logic [31:0] pr [L];
  always @(posedge clk) begin
    pq[0] <= (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
    pr[0] <= (div_divisor == 0) ? div_dividend  : div_dividend % div_divisor;
    for (int k = 1; k < L; k++) begin
      pq[k] <= pq[k-1];
      pr[k] <= pr[k-1];
    end
  end
  assign div_quotient  = pq[L-1];
  assign div_remainder = pr[L-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic [31:0] a, input logic [31:0] b, input logic sg);
    if (id) begin
      req_dividend[63:32] = a; req_divisor[63:32] = b; req_signed[1] = sg;
    end else begin
      req_dividend[31:0]  = a; req_divisor[31:0]  = b; req_signed[0] = sg;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic single(input string tag, input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic [31:0] ma, input logic [31:0] mb,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    int edges;
    @(posedge clk); #1;
    set_req(id, a, b, sg);
    req_valid = id ? 2'b10 : 2'b01;
    #1;
    check({tag, ".ready"}, req_ready, id ? 2'b10 : 2'b01);
    check({tag, ".mag_a"}, div_dividend, ma);
    check({tag, ".mag_b"}, div_divisor, mb);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1;
    check({tag, ".idle_a"}, div_dividend, 0);
    edges = 0;
    while (!resp_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, ".lat"}, edges, L);
    check({tag, ".id"}, resp_id, id);
    check({tag, ".q"}, resp_quotient, eq);
    check({tag, ".r"}, resp_remainder, er);
    check({tag, ".dbz"}, resp_dbz, edbz);
    @(posedge clk); #1;
    check({tag, ".popped"}, resp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, got, stale;
    reset        = 1'b0;
    req_valid    = 2'b11;
    req_dividend = {32'd200, 32'd100};
    req_divisor  = {32'd3, 32'd7};
    req_signed   = 2'b00;
    resp_ready   = 1'b1;
    #2;
    check("rst.ready", req_ready, 0);
    check("rst.valid", resp_valid, 0);
    check("rst.id", resp_id, 0);
    check("rst.q", resp_quotient, 0);
    check("rst.r", resp_remainder, 0);
    check("rst.dbz", resp_dbz, 0);
    check("rst.div_a", div_dividend, 0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;

    single("u100_7",   1'b0, 32'd100,        32'd7,          1'b0, 32'd100,        32'd7,
           32'd14,         32'd2,          1'b0);
    single("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          1'b1, 32'd7,          32'd2,
           32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    single("s7_-2",    1'b0, 32'd7,          32'hFFFF_FFFE,  1'b1, 32'd7,          32'd2,
           32'hFFFF_FFFD,  32'd1,          1'b0);
    single("ubig_16",  1'b1, 32'hFFFF_FFFF,  32'd16,         1'b0, 32'hFFFF_FFFF,  32'd16,
           32'h0FFF_FFFF,  32'd15,         1'b0);
    single("u5_0",     1'b0, 32'd5,          32'd0,          1'b0, 32'd5,          32'd0,
           32'hFFFF_FFFF,  32'd5,          1'b1);
    single("s-5_0",    1'b1, 32'hFFFF_FFFB,  32'd0,          1'b1, 32'd5,          32'd0,
           32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1);
    single("smin_-1",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd1,
           32'h8000_0000,  32'd0,          1'b0);

    // Round robin with both requesters held valid.
    pulse_reset();
    set_req(1'b0, 32'd100, 32'd7, 1'b0);
    set_req(1'b1, 32'd200, 32'd3, 1'b0);
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr.grant%0d", i), req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    got = 0; n = 0;
    while (got < 6 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (resp_valid) begin
        check($sformatf("rr.id%0d", got), resp_id, got % 2);
        check($sformatf("rr.q%0d", got), resp_quotient, (got % 2 == 1) ? 32'd66 : 32'd14);
        got++;
      end
    end
    check("rr.count", got, 6);

    // Credit exhaustion with the consumer stalled.
    pulse_reset();
    resp_ready = 1'b0;
    set_req(1'b0, 32'd100, 32'd7, 1'b0);
    req_valid = 2'b01;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready[0]) n++;
      @(posedge clk); #1;
    end
    check("cred.issues", n, 8);
    check("cred.ready0", req_ready, 0);
    check("cred.head_q", resp_quotient, 14);
    @(posedge clk); #1;
    check("cred.hold_q", resp_quotient, 14);
    check("cred.hold_v", resp_valid, 1);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req_ready[0]) n++;
      @(posedge clk); #1;
    end
    check("cred.after_pop", n, 1);
    req_valid = 2'b00;

    // Reset with three in flight and two buffered.
    pulse_reset();
    req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("mid.buffered", resp_valid, 1);
    req_valid = 2'b01;
    reset = 1'b0;
    #1;
    check("mid.valid0", resp_valid, 0);
    check("mid.ready0", req_ready, 0);
    check("mid.q0", resp_quotient, 0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    reset = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (resp_valid) stale++;
    end
    check("mid.stale", stale, 0);
    set_req(1'b0, 32'd50, 32'd5, 1'b0);
    req_valid = 2'b01;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready[0]) n++;
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    check("mid.credits", n, 8);
    resp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (resp_valid) begin
        if (got == 0) begin
          check("mid.first_q", resp_quotient, 10);
          check("mid.first_r", resp_remainder, 0);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    check("mid.drained", got, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_scheduler.md
DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 Parameter CYCLE, default 8, stage count of the attached pipelined divider; issue-to-result latency L = CYCLE-1 cycles.
REQ-003 Parameter DEPTH, default 8, response FIFO entries; SHALL be >= CYCLE.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  2  per-requester request valid.
REQ-007 req_ready  out  2  per-requester accept.
REQ-008 req_dividend  in  2*WIDTH  requester i operand at bits [i*WIDTH +: WIDTH].
REQ-009 req_divisor  in  2*WIDTH  same packing.
REQ-010 req_signed  in  2  1 = two's-complement division.
REQ-011 div_dividend  out  WIDTH  unsigned magnitude to divider.
REQ-012 div_divisor  out  WIDTH  unsigned magnitude to divider.
REQ-013 div_quotient  in  WIDTH  divider quotient, L cycles after issue.
REQ-014 div_remainder  in  WIDTH  divider remainder, L cycles after issue.
REQ-015 resp_valid  out  1  FIFO head valid.
REQ-016 resp_ready  in  1  consumer accept.
REQ-017 resp_id  out  1  requester index of head.
REQ-018 resp_quotient  out  WIDTH  final quotient.
REQ-019 resp_remainder  out  WIDTH  final remainder.
REQ-020 resp_dbz  out  1  divisor was zero.

Function
REQ-021 Issue SHALL occur on a cycle where req_valid[i] & req_ready[i]; at most one issue per cycle.
REQ-022 req_ready SHALL be one-hot or zero: granted requester only, and only when credits > 0.
REQ-023 Arbitration SHALL be round-robin: with both valid, grant the requester not issued last; single valid is granted directly; pointer updates only on issue.
REQ-024 credits SHALL start at DEPTH, decrement on issue, increment on resp handshake, stay unchanged when both occur in one cycle; never below 0 or above DEPTH.
REQ-025 div_dividend/div_divisor SHALL be combinational from the granted operands: unchanged if unsigned, |x| if signed (|-2^(WIDTH-1)| = 2^(WIDTH-1)); zero when no issue.
REQ-026 A sideband shift register of depth L SHALL carry per issue: valid, id, signed, dividend sign, divisor sign, dbz flag, original dividend.
REQ-027 When the sideband tail is valid, div_quotient/div_remainder SHALL be corrected and pushed into the FIFO that same edge.
REQ-028 Signed correction: quotient negated if dividend sign != divisor sign; remainder negated if dividend negative.
REQ-029 Divide-by-zero SHALL override: quotient all ones, remainder = original dividend, resp_dbz = 1, signed or unsigned.
REQ-030 -2^(WIDTH-1) / -1 signed SHALL yield quotient -2^(WIDTH-1), remainder 0, resp_dbz = 0.
REQ-031 FIFO SHALL be first-in-first-out; head held stable while resp_valid & !resp_ready.
REQ-032 FIFO push and pop in one cycle SHALL both take effect; by REQ-024 a push to a full FIFO SHALL never occur.
REQ-033 Responses SHALL retire in issue order regardless of id.

Reset
REQ-034 reset low SHALL immediately clear: sideband valids, FIFO pointers/count, credits = DEPTH, RR pointer = 1 (requester 0 wins first tie).
REQ-035 During reset: req_ready = 0, resp_valid = 0, resp_id = 0, resp_quotient = 0, resp_remainder = 0, resp_dbz = 0.
REQ-036 Reset mid-operation SHALL discard in-flight and buffered results; divider outputs after deassertion SHALL be ignored until new issues reach the tail.

Verification
REQ-037 Req0 unsigned 100/7, resp_ready=1 -> resp_valid exactly L cycles after issue, id 0, q 14, r 2, dbz 0.
REQ-038 Req1 signed -7/2 -> q -3 (0xFFFFFFFD), r -1 (0xFFFFFFFF); signed 7/-2 -> q -3, r 1.
REQ-039 Both requesters valid continuously, 6 issues -> ids alternate 0,1,0,1,0,1; responses in same order.
REQ-040 resp_ready=0, req0 valid continuously -> exactly DEPTH=8 issues then req_ready=0; one pop -> exactly one further issue.
REQ-041 Unsigned 5/0 and signed -5/0 -> q 0xFFFFFFFF, r 5 / 0xFFFFFFFB, dbz 1; signed 0x80000000/0xFFFFFFFF -> q 0x80000000, r 0.
REQ-042 Reset pulse with 3 in flight and 2 buffered -> resp_valid 0 at once, credits 8, no stale response ever emitted afterwards.
